// File: rtl/mac_pkg.sv
// ----------------------------------------------------------------------------
// mac_pkg: shared widths and state encoding for the MAC datapath | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mac_pkg;

  localparam int MAC_DATA_W = 4;
  localparam int MAC_PROD_W = 2 * MAC_DATA_W;
  localparam int MAC_ACC_W  = 16;
  localparam int MAC_TMO_W  = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ACCUM = 3'd3,
    ST_OUT   = 3'd4
  } mac_state_t;

  // True while a term is outstanding at the multiplier and the watchdog runs.
  function automatic logic in_flight(input mac_state_t s);
    return (s == ST_ISSUE) || (s == ST_WAIT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mac_wdog_counter.sv
// ----------------------------------------------------------------------------
// mac_wdog_counter: TMO_W up-counter with clear/enable and terminal count | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_wdog_counter
  import mac_pkg::*;
#(
  parameter int TMO_W = MAC_TMO_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [TMO_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the 2**TMO_W-th enabled cycle since the last clear.
  assign tc = enable && (&count);

endmodule

`default_nettype wire

// File: rtl/mac_accumulator.sv
// ----------------------------------------------------------------------------
// mac_accumulator: issues operand pairs to the multiplier and sums products | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mac_accumulator
  import mac_pkg::*;
#(
  parameter int DATA_W = MAC_DATA_W,
  parameter int PROD_W = MAC_PROD_W,
  parameter int ACC_W  = MAC_ACC_W,
  parameter int TMO_W  = MAC_TMO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_last,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic              mul_done,
  input  logic [PROD_W-1:0] mul_prod,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              overflow,
  output logic              err
);

  localparam int SUM_W = ACC_W + 1;

  mac_state_t       state;
  logic             last_q;
  logic             wd_enable;
  logic             wd_tc;
  logic             term_end;
  logic [SUM_W-1:0] sum;

  assign wd_enable = in_flight(state);
  assign term_end  = (state == ST_ACCUM) || wd_tc;
  assign sum       = {1'b0, acc_out} + SUM_W'(mul_prod);

  mac_wdog_counter #(
    .TMO_W (TMO_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (!wd_enable),
    .enable (wd_enable),
    .tc     (wd_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      last_q    <= 1'b0;
      acc_valid <= 1'b0;
      acc_out   <= '0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            mul_a     <= in_a;
            mul_b     <= in_b;
            last_q    <= in_last;
            in_ready  <= 1'b0;
            mul_start <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!mul_done) begin
            mul_start <= 1'b0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mul_done) begin
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_out <= sum[ACC_W-1:0];
          if (sum[ACC_W]) begin
            overflow <= 1'b1;
          end
        end
        ST_OUT: begin
          if (acc_ready) begin
            acc_valid <= 1'b0;
            acc_out   <= '0;
            overflow  <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          mul_start <= 1'b0;
          acc_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase

      // A completed or watchdog-aborted term leaves through the same exit;
      // an aborted term contributes nothing to the sum.
      if (term_end) begin
        mul_start <= 1'b0;
        if (wd_tc) begin
          err <= 1'b1;
        end
        if (last_q) begin
          acc_valid <= 1'b1;
          state     <= ST_OUT;
        end else begin
          in_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_accumulator.sv
// ----------------------------------------------------------------------------
// tb_mac_accumulator: directed scoreboard bench, 16-bit and 8-bit accumulators | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mac_accumulator;

  typedef struct {
    logic [15:0] a16;
    logic        o16;
    logic [7:0]  a8;
    logic        o8;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       in_last = 1'b0;
  logic       acc_ready = 1'b0;
  logic       stuck = 1'b0;

  logic       in_ready [2];
  logic       mstart   [2];
  logic [3:0] ma       [2];
  logic [3:0] mb       [2];
  logic       mdone    [2];
  logic [7:0] mprod    [2];
  logic       avalid   [2];
  logic       ovf      [2];
  logic       errs     [2];
  logic [15:0] acc_a;
  logic [7:0]  acc_b;

  mac_accumulator #(.ACC_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(mstart[0]),
    .mul_a(ma[0]), .mul_b(mb[0]), .mul_done(mdone[0]), .mul_prod(mprod[0]),
    .acc_valid(avalid[0]), .acc_ready(acc_ready), .acc_out(acc_a),
    .overflow(ovf[0]), .err(errs[0])
  );

  mac_accumulator #(.ACC_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(mstart[1]),
    .mul_a(ma[1]), .mul_b(mb[1]), .mul_done(mdone[1]), .mul_prod(mprod[1]),
    .acc_valid(avalid[1]), .acc_ready(acc_ready), .acc_out(acc_b),
    .overflow(ovf[1]), .err(errs[1])
  );

  // Sequential 4x4 multiplier model: 5 busy cycles, done is a level high while idle.
  int         busy   [2];
  logic       done_r [2];
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        busy[i]   <= 0;
        done_r[i] <= 1'b1;
        mprod[i]  <= '0;
      end else if (busy[i] != 0) begin
        busy[i] <= busy[i] - 1;
        if (busy[i] == 1) done_r[i] <= 1'b1;
      end else if (mstart[i]) begin
        busy[i]   <= 5;
        done_r[i] <= 1'b0;
        mprod[i]  <= 8'(ma[i]) * 8'(mb[i]);
      end
    end
  end
  assign mdone[0] = stuck | done_r[0];
  assign mdone[1] = stuck | done_r[1];

  // mul_start pulse monitor on the 16-bit instance
  int run = 0;
  int pulses = 0;
  int badw = 0;
  always @(negedge clk) begin
    if (mstart[0]) begin
      run <= run + 1;
    end else if (run != 0) begin
      pulses <= pulses + 1;
      if (run != 2) badw <= badw + 1;
      run <= 0;
    end
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  logic [15:0] m16 = '0;
  logic        mo16 = 1'b0;
  logic [7:0]  m8 = '0;
  logic        mo8 = 1'b0;
  logic        me = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m16 = '0; mo16 = 1'b0; m8 = '0; mo8 = 1'b0; me = 1'b0;
  endtask

  // Drive one pair; in_valid stays high after a non-last term.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last,
                      input logic drop);
    int   n = 0;
    logic [16:0] s16;
    logic [8:0]  s8;
    exp_t e;
    @(negedge clk);
    while (!in_ready[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(n < 100), 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(posedge clk); #1;
    if (last) in_valid = 1'b0;
    check("mul_a_held", 32'(ma[0]), 32'(a));
    check("mul_b_held", 32'(mb[0]), 32'(b));
    if (drop) begin
      me = 1'b1;
    end else begin
      s16 = {1'b0, m16} + 17'(a * b);
      s8  = {1'b0, m8} + 9'(8'(a) * 8'(b));
      m16 = s16[15:0]; mo16 = mo16 | s16[16];
      m8  = s8[7:0];   mo8  = mo8 | s8[8];
    end
    if (last) begin
      e.a16 = m16; e.o16 = mo16; e.a8 = m8; e.o8 = mo8; e.e = me;
      sb.push_back(e);
      model_clear();
    end
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall, then accept.
  task automatic wait_result(input int exp_lat, input int hold);
    int   cyc = 0;
    exp_t e;
    while (!avalid[0] && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_lat));
    check("sb_nonempty", 32'(sb.size()), 1);
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.a16 = '0; e.o16 = 1'b0; e.a8 = '0; e.o8 = 1'b0; e.e = 1'b0;
    end
    check("acc16", 32'(acc_a), 32'(e.a16));
    check("ovf16", 32'(ovf[0]), 32'(e.o16));
    check("err16", 32'(errs[0]), 32'(e.e));
    check("valid8", 32'(avalid[1]), 1);
    check("acc8", 32'(acc_b), 32'(e.a8));
    check("ovf8", 32'(ovf[1]), 32'(e.o8));
    check("err8", 32'(errs[1]), 32'(e.e));
    check("in_ready_out", 32'(in_ready[0]), 0);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(avalid[1]), 1);
      check("hold_acc8", 32'(acc_b), 32'(e.a8));
      check("hold_ovf8", 32'(ovf[1]), 32'(e.o8));
    end
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    check("clr_valid", 32'(avalid[0]), 0);
    check("clr_acc16", 32'(acc_a), 0);
    check("clr_ovf8", 32'(ovf[1]), 0);
    check("clr_err16", 32'(errs[0]), 0);
    check("clr_in_ready", 32'(in_ready[0]), 1);
  endtask

  int p0;

  initial begin
    // 1. reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rst_in_ready", 32'(in_ready[i]), 1);
      check("rst_valid", 32'(avalid[i]), 0);
      check("rst_start", 32'(mstart[i]), 0);
      check("rst_ovf", 32'(ovf[i]), 0);
      check("rst_err", 32'(errs[i]), 0);
    end
    check("rst_acc16", 32'(acc_a), 0);
    check("rst_acc8", 32'(acc_b), 0);

    // 2. single pair
    send(4'd8, 4'd3, 1'b1, 1'b0);
    wait_result(8, 0);

    // 3. three-term sequence, in_valid held between terms
    p0 = pulses;
    send(4'd8, 4'd3, 1'b0, 1'b0);
    send(4'd11, 4'd6, 1'b0, 1'b0);
    send(4'd5, 4'd13, 1'b1, 1'b0);
    wait_result(8, 0);
    check("start_pulses", 32'(pulses - p0), 3);
    check("start_width", 32'(badw), 0);

    // 4. wrap in the 8-bit accumulator with a stalled consumer
    send(4'd15, 4'd15, 1'b0, 1'b0);
    send(4'd15, 4'd15, 1'b1, 1'b0);
    wait_result(8, 10);

    // 5. reset during WAIT of term 2 discards the partial sum
    send(4'd8, 4'd3, 1'b0, 1'b0);
    send(4'd11, 4'd6, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("wait_start_low", 32'(mstart[0]), 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_clear();
    check("mid_rst_in_ready", 32'(in_ready[0]), 1);
    check("mid_rst_acc", 32'(acc_a), 0);
    check("mid_rst_valid", 32'(avalid[0]), 0);
    send(4'd2, 4'd3, 1'b1, 1'b0);
    wait_result(8, 0);

    // 6. multiplier stuck idle: watchdog aborts the term
    stuck = 1'b1;
    send(4'd4, 4'd4, 1'b1, 1'b1);
    wait_result(64, 0);
    stuck = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
